// File: rtl/mem_bus_pkg.sv
// Shared types and owner encoding for the two-requester memory bus arbiter.
package mem_bus_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StOwnI,
    StOwnD
  } arb_state_t;

  localparam logic [1:0] OwnerNone = 2'd0;
  localparam logic [1:0] OwnerI    = 2'd1;
  localparam logic [1:0] OwnerD    = 2'd2;

  function automatic logic [1:0] state_owner(arb_state_t s);
    case (s)
      StOwnI:  return OwnerI;
      StOwnD:  return OwnerD;
      default: return OwnerNone;
    endcase
  endfunction

endpackage

// File: rtl/bus_port_mux.sv
// Combinational bus command select and per-requester stall generation.
module bus_port_mux
  import mem_bus_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
) (
  input  logic [1:0]        owner,
  input  logic [ADDR_W-1:0] i_address,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] d_address,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [31:0]       d_writedata,
  input  logic [3:0]        d_byteenable,
  input  logic              waitrequest,
  output logic [ADDR_W-1:0] address,
  output logic              read,
  output logic              write,
  output logic [31:0]       writedata,
  output logic [3:0]        byteenable,
  output logic              i_waitrequest,
  output logic              d_waitrequest
);

  always_comb begin
    address       = '0;
    read          = 1'b0;
    write         = 1'b0;
    writedata     = '0;
    byteenable    = '0;
    i_waitrequest = 1'b1;
    d_waitrequest = 1'b1;
    case (owner)
      OwnerI: begin
        address       = i_address;
        read          = i_read;
        byteenable    = 4'hF;
        i_waitrequest = waitrequest;
      end
      OwnerD: begin
        address       = d_address;
        // Write wins so the bus never sees both strobes together.
        read          = d_read & ~d_write;
        write         = d_write;
        writedata     = d_writedata;
        byteenable    = d_byteenable;
        d_waitrequest = waitrequest;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Locked round-robin arbiter sharing one Avalon-MM master between fetch (I) and data (D).
module mem_bus_arbiter
  import mem_bus_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] i_address,
  input  logic              i_read,
  output logic              i_waitrequest,
  output logic [31:0]       i_readdata,
  input  logic [ADDR_W-1:0] d_address,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [31:0]       d_writedata,
  input  logic [3:0]        d_byteenable,
  output logic              d_waitrequest,
  output logic [31:0]       d_readdata,
  output logic [ADDR_W-1:0] address,
  output logic              read,
  output logic              write,
  output logic [31:0]       writedata,
  output logic [3:0]        byteenable,
  input  logic              waitrequest,
  input  logic [31:0]       readdata,
  output logic [1:0]        owner,
  output logic [CNT_W-1:0]  i_done_cnt,
  output logic [CNT_W-1:0]  d_done_cnt
);

  arb_state_t       state_q, state_d;
  logic             last_is_d_q, last_is_d_d;
  logic [CNT_W-1:0] i_cnt_q, d_cnt_q;
  logic             i_req, d_req, i_done, d_done;

  assign i_req  = i_read;
  assign d_req  = d_read | d_write;
  assign i_done = (state_q == StOwnI) && i_req && !waitrequest;
  assign d_done = (state_q == StOwnD) && d_req && !waitrequest;

  always_comb begin
    state_d     = state_q;
    last_is_d_d = last_is_d_q;
    case (state_q)
      StIdle: begin
        if (i_req && d_req) state_d = last_is_d_q ? StOwnI : StOwnD;
        else if (i_req)     state_d = StOwnI;
        else if (d_req)     state_d = StOwnD;
      end
      StOwnI: begin
        if (!i_req) begin
          state_d = StIdle;
        end else if (!waitrequest) begin
          last_is_d_d = 1'b0;
          state_d     = d_req ? StOwnD : StOwnI;
        end
      end
      StOwnD: begin
        if (!d_req) begin
          state_d = StIdle;
        end else if (!waitrequest) begin
          last_is_d_d = 1'b1;
          state_d     = i_req ? StOwnI : StOwnD;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      last_is_d_q <= 1'b1;
      i_cnt_q     <= '0;
      d_cnt_q     <= '0;
    end else begin
      state_q     <= state_d;
      last_is_d_q <= last_is_d_d;
      if (i_done) i_cnt_q <= i_cnt_q + CNT_W'(1);
      if (d_done) d_cnt_q <= d_cnt_q + CNT_W'(1);
    end
  end

  // Reset masks the owner so no strobe leaks out during the reset cycle.
  assign owner = reset ? OwnerNone : state_owner(state_q);

  bus_port_mux #(
    .ADDR_W (ADDR_W)
  ) u_mux (
    .owner         (owner),
    .i_address     (i_address),
    .i_read        (i_read),
    .d_address     (d_address),
    .d_read        (d_read),
    .d_write       (d_write),
    .d_writedata   (d_writedata),
    .d_byteenable  (d_byteenable),
    .waitrequest   (waitrequest),
    .address       (address),
    .read          (read),
    .write         (write),
    .writedata     (writedata),
    .byteenable    (byteenable),
    .i_waitrequest (i_waitrequest),
    .d_waitrequest (d_waitrequest)
  );

  assign i_readdata = readdata;
  assign d_readdata = readdata;
  assign i_done_cnt = i_cnt_q;
  assign d_done_cnt = d_cnt_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench: directed vector table, hand sequences, then random vs. reference model.
module tb_mem_bus_arbiter;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned CNT_W  = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic [ADDR_W-1:0] i_address, d_address, address;
  logic              i_read, i_waitrequest, d_read, d_write, d_waitrequest;
  logic [31:0]       i_readdata, d_readdata, d_writedata, writedata, readdata;
  logic [3:0]        d_byteenable, byteenable;
  logic              read, write, waitrequest;
  logic [1:0]        owner;
  logic [CNT_W-1:0]  i_done_cnt, d_done_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_bus_arbiter #(
    .ADDR_W (ADDR_W),
    .CNT_W  (CNT_W)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .i_address     (i_address),
    .i_read        (i_read),
    .i_waitrequest (i_waitrequest),
    .i_readdata    (i_readdata),
    .d_address     (d_address),
    .d_read        (d_read),
    .d_write       (d_write),
    .d_writedata   (d_writedata),
    .d_byteenable  (d_byteenable),
    .d_waitrequest (d_waitrequest),
    .d_readdata    (d_readdata),
    .address       (address),
    .read          (read),
    .write         (write),
    .writedata     (writedata),
    .byteenable    (byteenable),
    .waitrequest   (waitrequest),
    .readdata      (readdata),
    .owner         (owner),
    .i_done_cnt    (i_done_cnt),
    .d_done_cnt    (d_done_cnt)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Advance one clock; inputs are then changed 1 time unit after the edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        rst, ird, drd, dwr, wr;
    logic [1:0]  owner;
    logic        read, write, iw, dw;
    logic [31:0] addr;
    logic [3:0]  icnt, dcnt;
  } vec_t;

  vec_t vecs[16];

  // Reference model state
  int m_owner, m_last, m_icnt, m_dcnt;

  task automatic model_reset();
    m_owner = 0;
    m_last  = 2;
    m_icnt  = 0;
    m_dcnt  = 0;
  endtask

  task automatic model_edge();
    bit ir, dr;
    ir = i_read;
    dr = d_read | d_write;
    if (reset) begin
      model_reset();
    end else if (m_owner == 0) begin
      if (ir && dr)  m_owner = (m_last == 1) ? 2 : 1;
      else if (ir)   m_owner = 1;
      else if (dr)   m_owner = 2;
    end else begin
      bit own_req, oth_req;
      own_req = (m_owner == 1) ? ir : dr;
      oth_req = (m_owner == 1) ? dr : ir;
      if (!own_req) begin
        m_owner = 0;
      end else if (!waitrequest) begin
        if (m_owner == 1) m_icnt = (m_icnt + 1) % 16;
        else              m_dcnt = (m_dcnt + 1) % 16;
        m_last = m_owner;
        if (oth_req) m_owner = 3 - m_owner;
      end
    end
  endtask

  task automatic model_check();
    int eo;
    logic [31:0] ea, ewd;
    logic er, ew, eiw, edw;
    logic [3:0] ebe;
    eo  = reset ? 0 : m_owner;
    ea  = 0; er = 0; ew = 0; ewd = 0; ebe = 0; eiw = 1; edw = 1;
    if (eo == 1) begin
      ea = i_address; er = i_read; ebe = 4'hF; eiw = waitrequest;
    end else if (eo == 2) begin
      ea = d_address; er = d_read; ew = d_write; ewd = d_writedata;
      ebe = d_byteenable; edw = waitrequest;
    end
    chk("rnd_owner", owner, eo);
    chk("rnd_address", address, ea);
    chk("rnd_read", read, er);
    chk("rnd_write", write, ew);
    chk("rnd_writedata", writedata, ewd);
    chk("rnd_byteenable", byteenable, ebe);
    chk("rnd_i_wait", i_waitrequest, eiw);
    chk("rnd_d_wait", d_waitrequest, edw);
    chk("rnd_i_rdata", i_readdata, readdata);
    chk("rnd_d_rdata", d_readdata, readdata);
    chk("rnd_i_cnt", i_done_cnt, m_icnt);
    chk("rnd_d_cnt", d_done_cnt, m_dcnt);
    chk("rnd_rw_excl", read & write, 0);
  endtask

  initial begin
    //            rst ird drd dwr wr own rd wr iw dw addr          ic dc
    vecs[0]  = '{1, 1, 0, 1, 0, 0, 0, 0, 1, 1, 32'h0,        0, 0};
    vecs[1]  = '{0, 1, 0, 1, 0, 0, 0, 0, 1, 1, 32'h0,        0, 0};
    vecs[2]  = '{0, 1, 0, 1, 0, 1, 1, 0, 0, 1, 32'hBFC00000, 0, 0};
    vecs[3]  = '{0, 0, 0, 1, 0, 2, 0, 1, 1, 0, 32'h1000,     1, 0};
    vecs[4]  = '{0, 0, 0, 0, 0, 2, 0, 0, 1, 0, 32'h1000,     1, 1};
    vecs[5]  = '{0, 0, 0, 1, 1, 0, 0, 0, 1, 1, 32'h0,        1, 1};
    vecs[6]  = '{0, 1, 0, 1, 1, 2, 0, 1, 1, 1, 32'h1000,     1, 1};
    vecs[7]  = '{0, 1, 0, 1, 1, 2, 0, 1, 1, 1, 32'h1000,     1, 1};
    vecs[8]  = '{0, 1, 0, 1, 1, 2, 0, 1, 1, 1, 32'h1000,     1, 1};
    vecs[9]  = '{0, 1, 0, 1, 0, 2, 0, 1, 1, 0, 32'h1000,     1, 1};
    vecs[10] = '{0, 1, 0, 0, 0, 1, 1, 0, 0, 1, 32'hBFC00000, 1, 2};
    vecs[11] = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 32'hBFC00000, 2, 2};
    vecs[12] = '{0, 0, 0, 1, 0, 0, 0, 0, 1, 1, 32'h0,        2, 2};
    vecs[13] = '{0, 0, 0, 1, 1, 2, 0, 1, 1, 1, 32'h1000,     2, 2};
    vecs[14] = '{1, 0, 0, 1, 1, 0, 0, 0, 1, 1, 32'h0,        2, 2};
    vecs[15] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 32'h0,        0, 0};

    reset = 1; i_read = 0; d_read = 0; d_write = 0; waitrequest = 0;
    i_address = 32'hBFC00000; d_address = 32'h1000;
    d_writedata = 32'h12345678; d_byteenable = 4'b0011; readdata = 32'hA5A5_0001;
    next_cycle();

    // Directed vector table
    foreach (vecs[k]) begin
      reset = vecs[k].rst; i_read = vecs[k].ird; d_read = vecs[k].drd;
      d_write = vecs[k].dwr; waitrequest = vecs[k].wr; readdata = $urandom;
      #3;
      chk($sformatf("v%0d_owner", k), owner, vecs[k].owner);
      chk($sformatf("v%0d_read", k), read, vecs[k].read);
      chk($sformatf("v%0d_write", k), write, vecs[k].write);
      chk($sformatf("v%0d_i_wait", k), i_waitrequest, vecs[k].iw);
      chk($sformatf("v%0d_d_wait", k), d_waitrequest, vecs[k].dw);
      chk($sformatf("v%0d_i_cnt", k), i_done_cnt, vecs[k].icnt);
      chk($sformatf("v%0d_d_cnt", k), d_done_cnt, vecs[k].dcnt);
      if (!vecs[k].rst) chk($sformatf("v%0d_addr", k), address, vecs[k].addr);
      if (vecs[k].owner == 2) begin
        chk($sformatf("v%0d_wdata", k), writedata, 32'h12345678);
        chk($sformatf("v%0d_be", k), byteenable, 4'b0011);
      end
      if (vecs[k].owner == 1) chk($sformatf("v%0d_be_i", k), byteenable, 4'hF);
      chk($sformatf("v%0d_rdata", k), d_readdata, readdata);
      next_cycle();
    end

    // Both requesting continuously: strict alternation starting with I
    reset = 1; i_read = 1; d_read = 1; d_write = 0; waitrequest = 0;
    next_cycle();
    reset = 0;
    next_cycle();
    for (int k = 0; k < 8; k++) begin
      #3;
      chk($sformatf("alt%0d_owner", k), owner, (k % 2 == 0) ? 2'd1 : 2'd2);
      next_cycle();
    end
    i_read = 0; d_read = 0;
    #3;
    chk("alt_i_cnt", i_done_cnt, 4);
    chk("alt_d_cnt", d_done_cnt, 4);
    next_cycle();

    // 17 back-to-back I reads: 4-bit counter wraps to 1
    reset = 1;
    next_cycle();
    reset = 0; i_read = 1;
    next_cycle();
    for (int k = 0; k < 17; k++) begin
      #3;
      chk($sformatf("wrap%0d_d_wait", k), d_waitrequest, 1);
      chk($sformatf("wrap%0d_read", k), read, 1);
      next_cycle();
    end
    i_read = 0;
    #3;
    chk("wrap_i_cnt", i_done_cnt, 1);
    next_cycle();

    // Randomized traffic against the reference model
    reset = 1;
    next_cycle();
    model_reset();
    reset = 0;
    for (int c = 0; c < 3000; c++) begin
      int dsel;
      reset        = ($urandom_range(0, 59) == 0);
      i_read       = ($urandom_range(0, 9) < 7);
      dsel         = $urandom_range(0, 2);
      d_read       = (dsel == 1);
      d_write      = (dsel == 2);
      waitrequest  = ($urandom_range(0, 9) < 4);
      i_address    = $urandom;
      d_address    = $urandom;
      d_writedata  = $urandom;
      d_byteenable = 4'($urandom);
      readdata     = $urandom;
      #3;
      model_check();
      model_edge();
      next_cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
